// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch flush, load-use bubble, jump flush and multi-cycle mul/div stall.
// Optional performance counters (stall_cycles, flush_count) are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  input  logic       ex_branch_taken,
  input  logic       ex_muldiv_start,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       rst_IF_ID,
  output logic       rst_ID_EX,
  output logic       busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MULDIV = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_load_use;

  assign w_load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    rst_IF_ID   = 1'b0;
    rst_ID_EX   = 1'b0;
    busy        = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          // Priority: branch > mul/div start > load-use > jump.
          if (ex_branch_taken) begin
            rst_IF_ID = 1'b1;
            rst_ID_EX = 1'b1;
          end else if (ex_muldiv_start) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            rst_ID_EX   = 1'b1;
            w_state_nxt = ST_MULDIV;
            w_cnt_nxt   = 4'(MULDIV_LAT - 1);
          end else if (w_load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            rst_ID_EX   = 1'b1;
          end else if (id_jump) begin
            rst_IF_ID = 1'b1;
          end
        end
        ST_MULDIV: begin
          busy        = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          rst_ID_EX   = 1'b1;
          if (r_cnt == 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_cnt_nxt = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  // Reset holds outputs low, so the stall count only sees non-reset cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (!pc_write) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (rst_IF_ID) r_flush_count  <= r_flush_count + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULDIV_LAT, default 4, SHALL set the EX-stage multiply/divide occupancy in cycles (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt as a source.
REQ-007 id_jump  input  1  ID instruction is an unconditional jump.
REQ-008 ex_rt  input  5  destination rt of the instruction in EX.
REQ-009 ex_mem_read  input  1  EX instruction is a load.
REQ-010 ex_branch_taken  input  1  EX branch resolved taken.
REQ-011 ex_muldiv_start  input  1  EX instruction starts a multi-cycle mul/div.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 if_id_write  output  1  IF/ID register load enable.
REQ-014 rst_IF_ID  output  1  synchronous flush of IF/ID.
REQ-015 rst_ID_EX  output  1  synchronous flush of ID/EX (bubble insert).
REQ-016 busy  output  1  high while in MULDIV state.

Function
REQ-017 States SHALL be RUN and MULDIV; a 4-bit down-counter cnt SHALL track MULDIV occupancy.
REQ-018 Outputs SHALL be combinational from state and current inputs (zero-cycle latency), so the pipeline registers act on the same posedge.
REQ-019 RUN defaults: pc_write=1, if_id_write=1, rst_IF_ID=0, rst_ID_EX=0, busy=0.
REQ-020 Priority in RUN SHALL be: branch > mul/div start > load-use > jump.
REQ-021 ex_branch_taken=1: rst_IF_ID=1, rst_ID_EX=1, pc_write=1; ex_muldiv_start is ignored that cycle.
REQ-022 ex_muldiv_start=1 (no branch): next state MULDIV, cnt<=MULDIV_LAT-1, pc_write=0, if_id_write=0, rst_ID_EX=1.
REQ-023 Load-use = ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt)); on load-use: pc_write=0, if_id_write=0, rst_ID_EX=1, rst_IF_ID=0, for exactly one cycle.
REQ-024 id_jump=1 with no higher-priority event: rst_IF_ID=1 only.
REQ-025 MULDIV: busy=1, pc_write=0, if_id_write=0, rst_ID_EX=1, rst_IF_ID=0; all of ex_branch_taken, id_jump, load-use and ex_muldiv_start are ignored.
REQ-026 MULDIV: cnt decrements each cycle; when cnt==1, next state RUN and cnt<=0; total stall = MULDIV_LAT cycles including the start cycle.
REQ-027 ex_rt==0 SHALL never trigger load-use.

Reset
REQ-028 rst=1 SHALL immediately force state=RUN, cnt=0, and all counters under REQ-031 to 0, regardless of clk.
REQ-029 While rst=1, outputs SHALL be pc_write=0, if_id_write=0, rst_IF_ID=0, rst_ID_EX=0, busy=0.
REQ-030 Reset asserted mid-MULDIV SHALL abandon the stall; after release, the first cycle is RUN with default outputs.

Configuration
REQ-031 Macro HAZARD_PERF_CNT_EN defined: add outputs stall_cycles (32, output; counts cycles with pc_write=0 and rst=0) and flush_count (32, output; counts cycles with rst_IF_ID=1); both wrap 0xFFFFFFFF->0.
REQ-032 Macro undefined: both ports and counters are absent; all other behaviour is identical.

Verification
REQ-033 Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle -> pc_write=0, if_id_write=0, rst_ID_EX=1 that cycle only; ex_rt=0, id_rs=0 -> no stall.
REQ-034 Mul/div: ex_muldiv_start pulse with MULDIV_LAT=4 -> busy high 3 cycles after the start edge, pc_write low 4 cycles total, then RUN defaults.
REQ-035 Simultaneous events: ex_branch_taken=1, ex_muldiv_start=1, load-use true -> rst_IF_ID=1, rst_ID_EX=1, pc_write=1, and state stays RUN.
REQ-036 Async reset mid-MULDIV: rst asserted between edges in cycle 2 -> busy=0 before the next posedge; after release, pc_write=1.
REQ-037 Jump: id_jump=1 alone -> rst_IF_ID=1, rst_ID_EX=0; the same jump during MULDIV -> ignored.
REQ-038 With HAZARD_PERF_CNT_EN, run the REQ-034 and REQ-035 sequences -> stall_cycles=4, flush_count=1.
